// File: rtl/sram_pkg.sv
// Shared widths, FSM encoding and helpers for the emulated 256Kx16 async SRAM responder.
package sram_pkg;

    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;

    localparam logic [SRAM_DATA_W-1:0] OOB_READ_VAL = 16'h0000;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    // Counters hold at all-ones instead of wrapping back to zero.
    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/sram_array.sv
// Single-port halfword RAM with per-byte write enables and a registered read port.
module sram_array
    import sram_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [IDX_W-1:0]       addr,
    input  logic [1:0]             we,
    input  logic [SRAM_DATA_W-1:0] wdata,
    input  logic                   re,
    output logic [SRAM_DATA_W-1:0] rdata
);

    logic [SRAM_DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we[1]) mem[addr][15:8] <= wdata[15:8];
        if (we[0]) mem[addr][7:0]  <= wdata[7:0];
    end

    // Output register reset maps onto the block-RAM output latch reset.
    always_ff @(posedge clk) begin
        if (!rst)
            rdata <= '0;
        else if (re)
            rdata <= mem[addr];
    end

endmodule

// File: rtl/sram_chip_responder.sv
// Pin-level responder for the external SRAM: clear sweep, bus decode, counters, sticky flags, DQ tristate.
module sram_chip_responder
    import sram_pkg::*;
#(
    parameter int                     DEPTH    = 1024,
    parameter logic [SRAM_DATA_W-1:0] INIT_VAL = 16'h0000,
    parameter bit                     STRICT   = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
    input  logic                   SRAM_WE_N,
    input  logic                   SRAM_CE_N,
    input  logic                   SRAM_OE_N,
    input  logic                   SRAM_UB_N,
    input  logic                   SRAM_LB_N,
    output logic                   init_busy,
    output logic [15:0]            rd_count,
    output logic [15:0]            wr_count,
    output logic                   oob_err,
    output logic                   init_err
);

    localparam int                   IDX_W     = $clog2(DEPTH);
    localparam logic [SRAM_ADDR_W:0] DEPTH_EXT = (SRAM_ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(DEPTH - 1);

    state_t                 state;
    state_t                 state_next;
    logic [IDX_W-1:0]       clr_ptr;

    logic                   sel;
    logic                   wr_req;
    logic                   rd_req;
    logic                   in_range;
    logic [1:0]             lane_en;
    logic                   write_go;
    logic                   read_go;

    logic [IDX_W-1:0]       ram_addr;
    logic [1:0]             ram_we;
    logic [SRAM_DATA_W-1:0] ram_wdata;
    logic                   ram_re;
    logic [SRAM_DATA_W-1:0] ram_rdata;

    logic                   dq_oe;
    logic                   rd_oob;
    logic [SRAM_DATA_W-1:0] rd_data;

    assign sel       = STRICT ? ~SRAM_CE_N : 1'b1;
    assign wr_req    = sel & ~SRAM_WE_N;
    assign rd_req    = sel & SRAM_WE_N & (STRICT ? ~SRAM_OE_N : 1'b1);
    assign lane_en   = STRICT ? {~SRAM_UB_N, ~SRAM_LB_N} : 2'b11;
    // Full-width compare so high address bits can never alias into the array.
    assign in_range  = {1'b0, SRAM_ADDR} < DEPTH_EXT;
    assign init_busy = (state == CLEAR);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= CLEAR;
            clr_ptr <= '0;
        end else begin
            state <= state_next;
            if (state == CLEAR)
                clr_ptr <= clr_ptr + IDX_W'(1);
        end
    end

    always_comb begin
        state_next = state;
        ram_addr   = SRAM_ADDR[IDX_W-1:0];
        ram_wdata  = SRAM_DQ;
        ram_we     = 2'b00;
        ram_re     = 1'b0;
        write_go   = 1'b0;
        read_go    = 1'b0;
        case (state)
            CLEAR: begin
                ram_addr  = clr_ptr;
                ram_wdata = INIT_VAL;
                ram_we    = 2'b11;
                if (clr_ptr == LAST_IDX)
                    state_next = IDLE;
            end
            IDLE: begin
                write_go = wr_req;
                read_go  = rd_req;
                if (wr_req && in_range)
                    ram_we = lane_en;
                ram_re = rd_req & in_range;
            end
            default: state_next = CLEAR;
        endcase
        // An access coinciding with reset is abandoned rather than committed.
        if (!rst) begin
            ram_we = 2'b00;
            ram_re = 1'b0;
        end
    end

    sram_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .addr  (ram_addr),
        .we    (ram_we),
        .wdata (ram_wdata),
        .re    (ram_re),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_count <= '0;
            wr_count <= '0;
            oob_err  <= 1'b0;
            init_err <= 1'b0;
            dq_oe    <= 1'b0;
            rd_oob   <= 1'b0;
        end else begin
            dq_oe <= read_go;
            if (read_go) begin
                rd_oob   <= ~in_range;
                rd_count <= sat_inc(rd_count);
            end
            if (write_go)
                wr_count <= sat_inc(wr_count);
            if ((read_go || write_go) && !in_range)
                oob_err <= 1'b1;
            if ((state == CLEAR) && sel)
                init_err <= 1'b1;
        end
    end

    assign rd_data = rd_oob ? OOB_READ_VAL : ram_rdata;

    // Release is combinational on WE_N so a read->write turnaround never fights the controller.
    assign SRAM_DQ = (dq_oe & SRAM_WE_N) ? rd_data : {SRAM_DATA_W{1'bz}};

endmodule

// File: tb/tb_sram_chip_responder.sv
// Scenario bench for sram_chip_responder (STRICT build); DQ is pulled up so a released bus reads all-ones.
module tb_sram_chip_responder;

    localparam int          DEPTH  = 64;
    localparam int          IW     = 6;
    localparam logic [15:0] INIT   = 16'h5A3C;
    localparam logic [15:0] Z_VIEW = 16'hFFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic [17:0] addr;
    logic        we_n, ce_n, oe_n, ub_n, lb_n;
    logic [15:0] dq_drv;
    logic        dq_en;
    tri1  [15:0] dq_bus;
    logic        init_busy;
    logic [15:0] rd_count, wr_count;
    logic        oob_err, init_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] m_mem [DEPTH];
    int          m_rd, m_wr;
    logic        m_oob, m_ierr;
    logic [15:0] exp_dq;

    assign dq_bus = dq_en ? dq_drv : 16'hzzzz;

    always #5 clk = ~clk;

    sram_chip_responder #(
        .DEPTH    (DEPTH),
        .INIT_VAL (INIT),
        .STRICT   (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .SRAM_ADDR (addr),
        .SRAM_DQ   (dq_bus),
        .SRAM_WE_N (we_n),
        .SRAM_CE_N (ce_n),
        .SRAM_OE_N (oe_n),
        .SRAM_UB_N (ub_n),
        .SRAM_LB_N (lb_n),
        .init_busy (init_busy),
        .rd_count  (rd_count),
        .wr_count  (wr_count),
        .oob_err   (oob_err),
        .init_err  (init_err)
    );

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = INIT;
        m_rd = 0; m_wr = 0; m_oob = 1'b0; m_ierr = 1'b0;
    endtask

    task automatic set_idle();
        addr = '0; we_n = 1'b1; ce_n = 1'b1; oe_n = 1'b1; ub_n = 1'b1; lb_n = 1'b1;
        dq_drv = '0; dq_en = 1'b0;
    endtask

    // One bus cycle in IDLE: drive pins, take the edge, advance the reference model, settle.
    task automatic bus_op(input logic [17:0] a, input logic w_n, input logic [15:0] d,
                          input logic c_n, input logic o_n, input logic u_n, input logic l_n);
        logic wr_m, rd_m, oob_m;
        addr = a; we_n = w_n; ce_n = c_n; oe_n = o_n; ub_n = u_n; lb_n = l_n;
        dq_drv = d; dq_en = ~w_n;
        @(posedge clk);
        wr_m   = ~c_n & ~w_n;
        rd_m   = ~c_n & w_n & ~o_n;
        oob_m  = (a >= 18'(DEPTH));
        exp_dq = w_n ? Z_VIEW : d;
        if (wr_m) begin
            if (oob_m) m_oob = 1'b1;
            else begin
                if (!u_n) m_mem[a[IW-1:0]][15:8] = d[15:8];
                if (!l_n) m_mem[a[IW-1:0]][7:0]  = d[7:0];
            end
            if (m_wr < 65535) m_wr++;
        end
        if (rd_m) begin
            exp_dq = oob_m ? 16'h0000 : m_mem[a[IW-1:0]];
            if (oob_m) m_oob = 1'b1;
            if (m_rd < 65535) m_rd++;
        end
        #1;
    endtask

    task automatic wr_op(input logic [17:0] a, input logic [15:0] d);
        bus_op(a, 1'b0, d, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic rd_op(input logic [17:0] a);
        bus_op(a, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic reset_and_sweep();
        set_idle();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (DEPTH) @(posedge clk);
        #1;
        model_reset();
    endtask

    task automatic test_reset();
        int cycles;
        logic dq_bad;
        set_idle();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (init_busy !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_busy: got %b want 1", init_busy); end
        n_checks++; if (rd_count !== 16'd0 || wr_count !== 16'd0) begin n_fail++; $display("[TB] FAIL rst_counts: got rd=%0d wr=%0d want 0/0", rd_count, wr_count); end
        n_checks++; if (oob_err !== 1'b0 || init_err !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_flags: got oob=%b init=%b want 0/0", oob_err, init_err); end
        n_checks++; if (dq_bus !== Z_VIEW) begin n_fail++; $display("[TB] FAIL rst_dq: got %h want released (%h)", dq_bus, Z_VIEW); end
        rst = 1'b1;
        cycles = 0;
        dq_bad = 1'b0;
        while (init_busy === 1'b1 && cycles < DEPTH + 8) begin
            @(posedge clk);
            #1;
            cycles++;
            if (dq_bus !== Z_VIEW) dq_bad = 1'b1;
        end
        n_checks++; if (cycles != DEPTH) begin n_fail++; $display("[TB] FAIL sweep_len: got %0d cycles want %0d", cycles, DEPTH); end
        n_checks++; if (dq_bad !== 1'b0) begin n_fail++; $display("[TB] FAIL sweep_dq: bus driven during sweep (got 1 want 0)"); end
        n_checks++; if (init_err !== 1'b0) begin n_fail++; $display("[TB] FAIL sweep_ierr: got %b want 0", init_err); end
        model_reset();
    endtask

    task automatic test_basic();
        wr_op(18'd5, 16'h1234);
        wr_op(18'd6, 16'hABCD);
        rd_op(18'd5);
        n_checks++; if (dq_bus !== 16'h1234) begin n_fail++; $display("[TB] FAIL basic_rd5: got %h want 1234", dq_bus); end
        rd_op(18'd6);
        n_checks++; if (dq_bus !== 16'hABCD) begin n_fail++; $display("[TB] FAIL basic_rd6: got %h want abcd", dq_bus); end
        n_checks++; if (rd_count !== 16'd2 || wr_count !== 16'd2) begin n_fail++; $display("[TB] FAIL basic_counts: got rd=%0d wr=%0d want 2/2", rd_count, wr_count); end
        bus_op(18'd6, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1);
        n_checks++; if (dq_bus !== Z_VIEW) begin n_fail++; $display("[TB] FAIL basic_release: got %h want %h", dq_bus, Z_VIEW); end
        n_checks++; if (rd_count !== 16'd2) begin n_fail++; $display("[TB] FAIL basic_idle_rd: got %0d want 2", rd_count); end
    endtask

    task automatic test_controller();
        wr_op(18'd4, 16'hBABE);
        wr_op(18'd5, 16'hCAFE);
        rd_op(18'd4);
        n_checks++; if (dq_bus !== 16'hBABE) begin n_fail++; $display("[TB] FAIL ctrl_lo: got %h want babe", dq_bus); end
        rd_op(18'd5);
        n_checks++; if (dq_bus !== 16'hCAFE) begin n_fail++; $display("[TB] FAIL ctrl_hi: got %h want cafe", dq_bus); end
        wr_op(18'd9, 16'h0F0F);
        rd_op(18'd9);
        n_checks++; if (dq_bus !== 16'h0F0F) begin n_fail++; $display("[TB] FAIL wr_then_rd: got %h want 0f0f", dq_bus); end
    endtask

    task automatic test_strict();
        wr_op(18'd3, 16'h1234);
        bus_op(18'd3, 1'b0, 16'hFFFF, 1'b0, 1'b1, 1'b1, 1'b0);
        rd_op(18'd3);
        n_checks++; if (dq_bus !== 16'h12FF) begin n_fail++; $display("[TB] FAIL lane_lo: got %h want 12ff", dq_bus); end
        bus_op(18'd3, 1'b0, 16'hAB77, 1'b0, 1'b1, 1'b0, 1'b1);
        rd_op(18'd3);
        n_checks++; if (dq_bus !== 16'hABFF) begin n_fail++; $display("[TB] FAIL lane_hi: got %h want abff", dq_bus); end
        bus_op(18'd3, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1);
        rd_op(18'd3);
        n_checks++; if (dq_bus !== 16'hABFF) begin n_fail++; $display("[TB] FAIL lane_none: got %h want abff", dq_bus); end
        n_checks++; if (wr_count !== 16'(m_wr)) begin n_fail++; $display("[TB] FAIL lane_none_cnt: got %0d want %0d", wr_count, m_wr); end
        bus_op(18'd3, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++; if (dq_bus !== Z_VIEW) begin n_fail++; $display("[TB] FAIL ce_off_dq: got %h want %h", dq_bus, Z_VIEW); end
        bus_op(18'd3, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++; if (dq_bus !== Z_VIEW) begin n_fail++; $display("[TB] FAIL oe_off_dq: got %h want %h", dq_bus, Z_VIEW); end
        n_checks++; if (rd_count !== 16'(m_rd)) begin n_fail++; $display("[TB] FAIL desel_rd_cnt: got %0d want %0d", rd_count, m_rd); end
    endtask

    task automatic test_oob();
        logic [15:0] wc;
        n_checks++; if (oob_err !== 1'b0) begin n_fail++; $display("[TB] FAIL oob_pre: got %b want 0", oob_err); end
        wc = wr_count;
        wr_op(18'(DEPTH), 16'h5555);
        n_checks++; if (oob_err !== 1'b1) begin n_fail++; $display("[TB] FAIL oob_flag: got %b want 1", oob_err); end
        n_checks++; if (wr_count !== wc + 16'd1) begin n_fail++; $display("[TB] FAIL oob_wr_cnt: got %0d want %0d", wr_count, wc + 16'd1); end
        rd_op(18'd0);
        n_checks++; if (dq_bus !== INIT) begin n_fail++; $display("[TB] FAIL oob_mem0: got %h want %h", dq_bus, INIT); end
        rd_op(18'(DEPTH));
        n_checks++; if (dq_bus !== 16'h0000) begin n_fail++; $display("[TB] FAIL oob_rd: got %h want 0000", dq_bus); end
        wr_op(18'h20005, 16'h4444);
        wr_op(18'(DEPTH + 5), 16'h4545);
        rd_op(18'd5);
        n_checks++; if (dq_bus !== 16'hCAFE) begin n_fail++; $display("[TB] FAIL oob_alias: got %h want cafe", dq_bus); end
    endtask

    task automatic test_random();
        logic [17:0] a;
        logic        w_n, c_n, o_n, u_n, l_n;
        logic [15:0] d;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 9) == 0) a = 18'($urandom);
            else a = 18'($urandom_range(0, DEPTH + 7));
            w_n = 1'($urandom_range(0, 1));
            c_n = ($urandom_range(0, 9) == 0);
            o_n = ($urandom_range(0, 4) == 0);
            u_n = ($urandom_range(0, 3) == 0);
            l_n = ($urandom_range(0, 3) == 0);
            d   = 16'($urandom);
            bus_op(a, w_n, d, c_n, o_n, u_n, l_n);
            if (w_n) begin
                n_checks++; if (dq_bus !== exp_dq) begin n_fail++; $display("[TB] FAIL rnd_dq[%0d] a=%h: got %h want %h", i, a, dq_bus, exp_dq); end
            end
            n_checks++; if (rd_count !== 16'(m_rd) || wr_count !== 16'(m_wr)) begin n_fail++; $display("[TB] FAIL rnd_cnt[%0d]: got rd=%0d wr=%0d want %0d/%0d", i, rd_count, wr_count, m_rd, m_wr); end
            n_checks++; if (oob_err !== m_oob || init_err !== m_ierr) begin n_fail++; $display("[TB] FAIL rnd_flags[%0d]: got oob=%b ierr=%b want %b/%b", i, oob_err, init_err, m_oob, m_ierr); end
        end
    endtask

    task automatic test_sweep_activity();
        int cycles;
        set_idle();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        addr = 18'd3; we_n = 1'b0; ce_n = 1'b0; ub_n = 1'b0; lb_n = 1'b0;
        dq_drv = 16'h1111; dq_en = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        set_idle();
        n_checks++; if (init_busy !== 1'b1) begin n_fail++; $display("[TB] FAIL busy_mid: got %b want 1", init_busy); end
        n_checks++; if (init_err !== 1'b1) begin n_fail++; $display("[TB] FAIL ierr_set: got %b want 1", init_err); end
        n_checks++; if (wr_count !== 16'd0) begin n_fail++; $display("[TB] FAIL sweep_wr_cnt: got %0d want 0", wr_count); end
        cycles = 0;
        while (init_busy === 1'b1 && cycles < DEPTH) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        n_checks++; if (init_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL sweep_end: got busy=%b want 0", init_busy); end
        model_reset();
        m_ierr = 1'b1;
        rd_op(18'd3);
        n_checks++; if (dq_bus !== INIT) begin n_fail++; $display("[TB] FAIL sweep_nowrite: got %h want %h", dq_bus, INIT); end
        n_checks++; if (init_err !== 1'b1) begin n_fail++; $display("[TB] FAIL ierr_sticky: got %b want 1", init_err); end

        wr_op(18'd7, 16'h7777);
        rd_op(18'd7);
        n_checks++; if (dq_bus !== 16'h7777) begin n_fail++; $display("[TB] FAIL pre_abort: got %h want 7777", dq_bus); end
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_checks++; if (dq_bus !== Z_VIEW) begin n_fail++; $display("[TB] FAIL abort_dq: got %h want %h", dq_bus, Z_VIEW); end
        n_checks++; if (init_busy !== 1'b1 || rd_count !== 16'd0) begin n_fail++; $display("[TB] FAIL abort_state: got busy=%b rd=%0d want 1/0", init_busy, rd_count); end
        set_idle();
        rst = 1'b1;
        repeat (DEPTH) @(posedge clk);
        #1;
        model_reset();
        n_checks++; if (init_busy !== 1'b0 || init_err !== 1'b0) begin n_fail++; $display("[TB] FAIL restart: got busy=%b ierr=%b want 0/0", init_busy, init_err); end
        rd_op(18'd7);
        n_checks++; if (dq_bus !== INIT) begin n_fail++; $display("[TB] FAIL restart_rd: got %h want %h", dq_bus, INIT); end
    endtask

    initial begin
        set_idle();
        rst = 1'b0;
        test_reset();
        test_basic();
        test_controller();
        test_strict();
        test_oob();
        reset_and_sweep();
        test_random();
        test_sweep_activity();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
